// File: rtl/noc_flit_serializer_pkg.sv
// Shared types and helpers for the NoC flit serializer.
// The FSM only needs to know whether any flit of the current head has gone out yet.
package noc_serializer_pkg;

    typedef enum logic {
        eIdle = 1'b0,
        eSend = 1'b1
    } state_e;

    // Index of the final flit; oversized length fields collapse to the last slot.
    function automatic int len_clamp(input int len, input int num_flits);
        return (len >= num_flits - 1) ? num_flits - 1 : len;
    endfunction

endpackage

// File: rtl/noc_flit_serializer_if.sv
// Serializer link bundle: FIFO head side (v_i/data_i/yumi_o) and downstream flit side.
// Signal suffixes are named from the serializer's point of view.
interface noc_flit_serializer_if #(
    parameter int flit_width_p = 16,
    parameter int num_flits_p  = 4
) ();
    logic                                v_i;
    logic [flit_width_p*num_flits_p-1:0] data_i;
    logic                                yumi_o;
    logic                                v_o;
    logic [flit_width_p-1:0]             data_o;
    logic                                last_o;
    logic                                ready_i;

    modport slave  (input  v_i, data_i, ready_i, output yumi_o, v_o, data_o, last_o);
    modport master (output v_i, data_i, ready_i, input  yumi_o, v_o, data_o, last_o);
endinterface

// File: rtl/noc_flit_serializer_counter.sv
// Flit index counter: synchronous active-low reset, clear takes priority over enable.
module noc_flit_counter #(
    parameter int width_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_o
);
    always_ff @(posedge clk_i) begin
        if (!reset_n_i)   count_o <= '0;
        else if (clear_i) count_o <= '0;
        else if (en_i)    count_o <= count_o + width_p'(1);
    end
endmodule

// File: rtl/noc_flit_serializer_sva.sv
// Protocol checks for the serializer; port list is plain so it can be bound or instantiated.
module noc_flit_serializer_sva
    import noc_serializer_pkg::*;
#(
    parameter int num_flits_p     = 4,
    parameter int lg_num_flits_lp = $clog2(num_flits_p)
) (
    input logic                       clk_i,
    input logic                       reset_n_i,
    input logic                       v_i,
    input logic                       ready_i,
    input logic                       yumi_o,
    input logic                       last_o,
    input state_e                     state_i,
    input logic [lg_num_flits_lp-1:0] cnt_i
);
    a_yumi_needs_head: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        yumi_o |-> (v_i && ready_i && last_o));

    a_no_mid_dequeue: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (state_i == eSend && !last_o) |-> !yumi_o);

    // The FIFO head cannot vanish once part of it has been sent.
    a_head_held: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (state_i == eSend) |-> v_i);

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        int'(cnt_i) <= num_flits_p - 1);
endmodule

// File: rtl/noc_flit_serializer.sv
// Flow-through serializer: emits the FIFO head packet as len+1 narrow flits and
// dequeues the head only when its final flit is accepted downstream.
module noc_flit_serializer
    import noc_serializer_pkg::*;
#(
    parameter int flit_width_p = 16,
    parameter int num_flits_p  = 4
) (
    input logic                 clk_i,
    input logic                 reset_n_i,
    noc_flit_serializer_if.slave link
);
    localparam int lg_num_flits_lp = $clog2(num_flits_p);

    state_e                     r_state;
    logic [lg_num_flits_lp-1:0] r_cnt;
    logic [lg_num_flits_lp-1:0] w_len;
    logic [lg_num_flits_lp-1:0] w_last_idx;
    logic [flit_width_p-1:0]    w_data;
    logic                       w_v;
    logic                       w_last;
    logic                       w_fire;
    logic                       w_done;
    logic                       w_adv;

    assign w_len      = link.data_i[lg_num_flits_lp-1:0];
    assign w_last_idx = lg_num_flits_lp'(len_clamp(int'(w_len), num_flits_p));

    // Reset masks the head so nothing is offered or dequeued while in reset.
    assign w_v    = link.v_i & reset_n_i;
    assign w_last = w_v & (r_cnt == w_last_idx);
    assign w_fire = w_v & link.ready_i;
    assign w_done = w_fire & w_last;
    assign w_adv  = w_fire & ~w_last;

    always_comb begin
        w_data = '0;
        for (int k = 0; k < num_flits_p; k++) begin
            if (r_cnt == lg_num_flits_lp'(k))
                w_data = link.data_i[k*flit_width_p +: flit_width_p];
        end
    end

    assign link.v_o    = w_v;
    assign link.data_o = w_data;
    assign link.last_o = w_last;
    assign link.yumi_o = w_done;

    noc_flit_counter #(.width_p(lg_num_flits_lp)) u_cnt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (w_done),
        .en_i      (w_adv),
        .count_o   (r_cnt)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i)  r_state <= eIdle;
        else if (w_done) r_state <= eIdle;
        else if (w_adv)  r_state <= eSend;
    end

    noc_flit_serializer_sva #(.num_flits_p(num_flits_p)) u_sva (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (link.v_i),
        .ready_i   (link.ready_i),
        .yumi_o    (w_done),
        .last_o    (w_last),
        .state_i   (r_state),
        .cnt_i     (r_cnt)
    );
endmodule

// File: tb/tb_noc_flit_serializer.sv
// Directed bench: 4-flit build for the main cases, 3-flit build for length clamping.
module tb_noc_flit_serializer;
    logic clk_i = 1'b0;
    logic reset_n_i;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk_i = ~clk_i;

    noc_flit_serializer_if #(.flit_width_p(8), .num_flits_p(4)) ifa ();
    noc_flit_serializer_if #(.flit_width_p(8), .num_flits_p(3)) ifb ();

    noc_flit_serializer #(.flit_width_p(8), .num_flits_p(4)) dut_a (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .link(ifa));
    noc_flit_serializer #(.flit_width_p(8), .num_flits_p(3)) dut_b (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .link(ifb));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_a(input string tag, input logic [7:0] d, input logic v,
                            input logic last, input logic yumi);
        @(negedge clk_i);
        chk({tag, "_data"}, ifa.data_o, d);
        chk({tag, "_v"},    ifa.v_o, v);
        chk({tag, "_last"}, ifa.last_o, last);
        chk({tag, "_yumi"}, ifa.yumi_o, yumi);
        tick();
    endtask

    task automatic expect_b(input string tag, input logic [7:0] d, input logic last,
                            input logic yumi);
        @(negedge clk_i);
        chk({tag, "_data"}, ifb.data_o, d);
        chk({tag, "_last"}, ifb.last_o, last);
        chk({tag, "_yumi"}, ifb.yumi_o, yumi);
        tick();
    endtask

    logic [31:0] heads [2];
    logic [7:0]  exp_flit [4];
    logic        exp_last [4];
    logic        exp_yumi;
    int          idx, hp, nyumi;

    initial begin
        reset_n_i   = 1'b0;
        ifa.v_i     = 1'b1;
        ifa.ready_i = 1'b1;
        ifa.data_i  = 32'hD4C3B2A7;
        ifb.v_i     = 1'b1;
        ifb.ready_i = 1'b1;
        ifb.data_i  = 24'h332213;

        @(negedge clk_i);
        chk("rst_v_a",    ifa.v_o, 1'b0);
        chk("rst_yumi_a", ifa.yumi_o, 1'b0);
        chk("rst_v_b",    ifb.v_o, 1'b0);
        tick();
        tick();
        reset_n_i = 1'b1;
        ifb.v_i   = 1'b0;

        // 4-flit packet, len=3, then a len=0 head with no bubble.
        ifa.data_i = 32'h44332203;
        expect_a("p4_f0", 8'h03, 1'b1, 1'b0, 1'b0);
        expect_a("p4_f1", 8'h22, 1'b1, 1'b0, 1'b0);
        expect_a("p4_f2", 8'h33, 1'b1, 1'b0, 1'b0);
        expect_a("p4_f3", 8'h44, 1'b1, 1'b1, 1'b1);
        ifa.data_i = 32'h11223344;
        expect_a("p1_f0", 8'h44, 1'b1, 1'b1, 1'b1);

        // len=1 with backpressure on flit 1.
        ifa.data_i = 32'h0000CCF5;
        expect_a("bp_f0", 8'hF5, 1'b1, 1'b0, 1'b0);
        ifa.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) expect_a("bp_hold", 8'hCC, 1'b1, 1'b1, 1'b0);
        ifa.ready_i = 1'b1;
        expect_a("bp_f1", 8'hCC, 1'b1, 1'b1, 1'b1);
        ifa.v_i    = 1'b0;
        ifa.data_i = '0;
        expect_a("idle", 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset after two flits of a 4-flit packet: resend from flit 0.
        ifa.v_i    = 1'b1;
        ifa.data_i = 32'hD4C3B2A7;
        expect_a("rp_f0", 8'hA7, 1'b1, 1'b0, 1'b0);
        expect_a("rp_f1", 8'hB2, 1'b1, 1'b0, 1'b0);
        reset_n_i = 1'b0;
        expect_a("rp_rst", 8'hC3, 1'b0, 1'b0, 1'b0);
        reset_n_i = 1'b1;
        expect_a("rp_r0", 8'hA7, 1'b1, 1'b0, 1'b0);
        expect_a("rp_r1", 8'hB2, 1'b1, 1'b0, 1'b0);
        expect_a("rp_r2", 8'hC3, 1'b1, 1'b0, 1'b0);
        expect_a("rp_r3", 8'hD4, 1'b1, 1'b1, 1'b1);

        // Two queued packets (len 2, len 0) under random ready.
        heads[0] = 32'h00635242;
        heads[1] = 32'h00000084;
        exp_flit[0] = 8'h42; exp_last[0] = 1'b0;
        exp_flit[1] = 8'h52; exp_last[1] = 1'b0;
        exp_flit[2] = 8'h63; exp_last[2] = 1'b1;
        exp_flit[3] = 8'h84; exp_last[3] = 1'b1;
        idx = 0; hp = 0; nyumi = 0;
        ifa.v_i    = 1'b1;
        ifa.data_i = heads[0];
        for (int c = 0; c < 80 && hp < 2; c++) begin
            ifa.ready_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            exp_yumi = ifa.ready_i & exp_last[idx];
            chk("rnd_yumi", ifa.yumi_o, exp_yumi);
            chk("rnd_data", ifa.data_o, exp_flit[idx]);
            chk("rnd_last", ifa.last_o, exp_last[idx]);
            if (ifa.yumi_o) nyumi++;
            if (ifa.ready_i) idx++;
            if (exp_yumi) hp++;
            tick();
            if (hp < 2) ifa.data_i = heads[hp];
            else        ifa.v_i    = 1'b0;
        end
        ifa.v_i = 1'b0;
        chk("rnd_done",  32'(hp), 32'd2);
        chk("rnd_flits", 32'(idx), 32'd4);
        chk("rnd_nyumi", 32'(nyumi), 32'd2);

        // len field 3 on a 3-flit build clamps to 3 flits.
        ifb.v_i    = 1'b1;
        ifb.data_i = 24'h332213;
        expect_b("cl_f0", 8'h13, 1'b0, 1'b0);
        expect_b("cl_f1", 8'h22, 1'b0, 1'b0);
        expect_b("cl_f2", 8'h33, 1'b1, 1'b1);
        ifb.data_i = 24'h000000;
        expect_b("cl_next", 8'h00, 1'b1, 1'b1);
        ifb.v_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/noc_flit_serializer.md
# noc_flit_serializer

Downstream consumer of the two-entry NoC FIFO: it takes one wide packet word from the FIFO head (valid/yumi) and emits it as a sequence of narrow flits on a valid/ready link toward the router output port. The FIFO head is dequeued only when the last flit of that packet is accepted, so no local packet buffer is needed. Flit count per packet is variable and is carried in a length field in flit 0.

## Interface
- flit_width_p, 16, width of one flit; must be ≥ lg_num_flits_lp
- num_flits_p, 4, max flits per packet; FIFO entry width = flit_width_p*num_flits_p; must be ≥ 2
- lg_num_flits_lp, $clog2(num_flits_p), derived, not overridable

- clk_i  in  1  single clock, all state on rising edge
- reset_n_i  in  1  synchronous, active-low reset
- v_i  in  1  FIFO head valid
- data_i  in  flit_width_p*num_flits_p  FIFO head packet; flit k = data_i[k*flit_width_p +: flit_width_p]
- yumi_o  out  1  dequeue FIFO head; asserted only with v_i
- v_o  out  1  flit valid to downstream
- data_o  out  flit_width_p  current flit
- last_o  out  1  current flit is the packet's final flit
- ready_i  in  1  downstream accepts flit when v_o & ready_i

## Operation
- Length: len = flit 0 bits [lg_num_flits_lp-1:0]; packet has len+1 flits. len ≥ num_flits_p-1 is clamped to num_flits_p flits.
- Flit counter cnt_r, lg_num_flits_lp bits; selects data_o = flit cnt_r of data_i.
- FSM states: IDLE (cnt_r==0, no flit of head sent), SEND (≥1 flit of head sent).
  - IDLE, v_i & ready_i, not last: cnt_r←1, →SEND.
  - IDLE, v_i & ready_i & last (len==0): yumi_o=1, stay IDLE.
  - SEND, ready_i, not last: cnt_r←cnt_r+1.
  - SEND, ready_i & last: yumi_o=1, cnt_r←0, →IDLE.
  - no ready_i: hold.
- last_o = v_o & (cnt_r == clamped len).
- v_o = v_i; in SEND, v_i low is a protocol violation (FIFO head cannot vanish without yumi); flagged by assertion.
- yumi_o = v_i & ready_i & last_o; FIFO never dequeued mid-packet, never when empty.
- v_o must not depend combinationally on ready_i.

## Timing
- Zero-latency flow-through: data_i→data_o, v_i→v_o, ready_i→yumi_o combinational same cycle.
- N-flit packet occupies exactly N accepted cycles; back-to-back packets with no bubble (next head's flit 0 the cycle after yumi_o).
- data_o/last_o stable while v_o & ~ready_i.
- Reset values (reset_n_i low, sampled at edge): cnt_r=0, state=IDLE; yumi_o=0 and v_o=0 during reset regardless of v_i.
- Reset mid-packet: cnt_r→0; head not dequeued; after reset the same head is resent from flit 0 (downstream sees a truncated packet; upstream recovery is the router's job).
- Counter wrap: cnt_r never exceeds num_flits_p-1; last-flit transition always clears to 0.
- Simultaneous FIFO enqueue on the same cycle as yumi_o is the FIFO's concern; serializer only sees the new head next cycle.

## Structure
- Package noc_serializer_pkg: state enum {eIdle, eSend}; function len_clamp(len, num_flits) returning last-flit index.
- Sub-module noc_flit_counter: up-counter with clear and enable, parameter width; instantiated once for cnt_r.
- Bind-able SVA module alongside: yumi_o→v_i, no yumi_o in SEND before last, v_i stable in SEND, cnt_r bound.

## Test plan
- flit_width_p=8, num_flits_p=4, head=0x44_33_22_03, ready_i=1 -> data_o 0x03,0x22,0x33,0x44 on 4 consecutive cycles, last_o and yumi_o only on 4th.
- head with len=0 (0x..._00) -> single flit, last_o=1 and yumi_o=1 in the same cycle; next head's flit 0 the following cycle.
- len=1 packet, ready_i low on flit 1 for 3 cycles -> data_o/last_o held at flit 1, yumi_o=0 until ready_i returns, then one yumi_o pulse.
- len field=3 on num_flits_p=3 build (len ≥ num_flits_p-1) -> exactly 3 flits, cnt_r never reaches 3.
- reset_n_i low after 2 flits of a 4-flit packet -> v_o=0, yumi_o=0 in reset; afterwards flit 0 resent, FIFO entry dequeued only once.
- two queued packets (len 2, len 0), ready_i random 50% -> 4 flits total in order, exactly two yumi_o pulses, each coinciding with last_o & ready_i.
